// File: rtl/t_toggle_receiver.sv
// Receiving end of a 2-phase toggle link: synchronises tgl_in, turns each level flip into an
// event, queues up to MAX_PEND events for a valid/ready consumer and returns a 2-phase ack.
module t_toggle_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_PEND    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgl_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ack_tgl,
  output logic [3:0]       pend_cnt,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int unsigned ArmW    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [ArmW-1:0] ArmLast = ArmW'(SYNC_STAGES);
  localparam logic [3:0]      MaxPend = 4'(MAX_PEND);

  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StPend,
    StFull
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev_q;
  logic [ArmW-1:0]        arm_cnt_q, arm_cnt_d;

  logic [3:0]       pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;

  logic armed;
  logic det;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detector
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
      prev_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArm;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    unique case (state_q)
      // Hold off detection until the reset-time level has fully propagated into prev_q.
      StArm: begin
        if (arm_cnt_q == ArmLast) begin
          state_d   = StIdle;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (push) begin
          state_d = (pend_d == MaxPend) ? StFull : StPend;
        end
      end
      StPend: begin
        if (push && !pop && (pend_d == MaxPend)) begin
          state_d = StFull;
        end else if (pop && !push && (pend_d == 4'd0)) begin
          state_d = StIdle;
        end
      end
      StFull: begin
        if (pop && !push) begin
          state_d = (pend_d == 4'd0) ? StIdle : StPend;
        end
      end
      default: state_d = StArm;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    armed = (state_q != StArm);
    det   = armed & (s ^ prev_q);
    pop   = valid_q & evt_ready;
    full  = (state_q == StFull);
    // A pop in the same cycle frees the slot the new event needs.
    push  = det & (~full | pop);
    drop  = det & full & ~pop;
  end

  // ---------------------------------------------------------------------------
  // Pending queue, counters, ack and overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = pend_q;
    unique case ({push, pop})
      2'b10:   pend_d = pend_q + 4'd1;
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
    valid_d = (pend_d != 4'd0);
    count_d = count_q + CNT_W'(push);
    ack_d   = ack_q ^ pop;
    ovf_d   = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 4'd0;
      valid_q <= 1'b0;
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign pend_cnt  = pend_q;
  assign evt_count = count_q;
  assign ack_tgl   = ack_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_t_toggle_receiver.sv
// Bench for t_toggle_receiver: directed scenarios plus a randomized run, all checked against
// an event-queue model that schedules each toggle's arrival by edge number.
module tb_t_toggle_receiver;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned MAX_PEND    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tgl_in;
  logic             evt_valid;
  logic             evt_ready;
  logic             ack_tgl;
  logic [3:0]       pend_cnt;
  logic [CNT_W-1:0] evt_count;
  logic             ovf;
  logic             clr_ovf;

  int checks = 0;
  int errors = 0;

  t_toggle_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .MAX_PEND   (MAX_PEND)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl_in   (tgl_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .ack_tgl  (ack_tgl),
    .pend_cnt (pend_cnt),
    .evt_count(evt_count),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: each flip is expected to take effect at a known edge number.
  int unsigned edges = 0;
  int unsigned ev_q[$];
  int          m_pend  = 0;
  int unsigned m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          m_ack   = 1'b0;
  bit          mv_ev, mv_pop, mv_acc;

  always @(posedge clk) edges <= edges + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q.delete();
      m_pend  <= 0;
      m_count <= 0;
      m_ovf   <= 1'b0;
      m_ack   <= 1'b0;
    end else begin
      mv_ev = (ev_q.size() > 0) && (ev_q[0] == edges + 1);
      if (mv_ev) void'(ev_q.pop_front());
      mv_pop = (m_pend > 0) && (evt_ready === 1'b1);
      mv_acc = mv_ev && ((m_pend < int'(MAX_PEND)) || mv_pop);
      m_pend <= m_pend + int'(mv_acc) - int'(mv_pop);
      if (mv_acc) m_count <= (m_count + 1) % (1 << CNT_W);
      if (mv_pop) m_ack <= ~m_ack;
      if (mv_ev && !mv_acc) m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
    end
  end

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flip();
    tgl_in = ~tgl_in;
    ev_q.push_back(edges + SYNC_STAGES + 1);
  endtask

  task automatic apply_reset(input logic lvl);
    rst_n     = 1'b0;
    tgl_in    = lvl;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL reset evt_valid got %0b want 0", evt_valid);
    end
    checks++;
    if (pend_cnt !== 4'd0) begin
      errors++; $display("FAIL reset pend_cnt got %0d want 0", pend_cnt);
    end
    checks++;
    if (evt_count !== '0) begin
      errors++; $display("FAIL reset evt_count got %0d want 0", evt_count);
    end
    checks++;
    if (ovf !== 1'b0 || ack_tgl !== 1'b0) begin
      errors++; $display("FAIL reset ovf/ack got %0b/%0b want 0/0", ovf, ack_tgl);
    end
  endtask

  task automatic test_single();
    apply_reset(1'b0);
    flip();
    tick(SYNC_STAGES);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single early_valid got %0b want 0", evt_valid);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b1 || pend_cnt !== 4'd1) begin
      errors++;
      $display("FAIL single valid/pend got %0b/%0d want 1/1", evt_valid, pend_cnt);
    end
    checks++;
    if (evt_count !== CNT_W'(1)) begin
      errors++; $display("FAIL single evt_count got %0d want 1", evt_count);
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || ack_tgl !== 1'b1) begin
      errors++;
      $display("FAIL single pop valid/ack got %0b/%0b want 0/1", evt_valid, ack_tgl);
    end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] c0;
    c0 = CNT_W'(m_count);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flip();
      tick(4);
    end
    tick(2);
    checks++;
    if (pend_cnt !== 4'(MAX_PEND)) begin
      errors++; $display("FAIL overflow pend_cnt got %0d want %0d", pend_cnt, MAX_PEND);
    end
    checks++;
    if (evt_count !== c0 + CNT_W'(3)) begin
      errors++; $display("FAIL overflow evt_count got %0d want %0d", evt_count, c0 + 3);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL overflow ovf got %0b want 1", ovf);
    end
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0 || pend_cnt !== 4'(MAX_PEND)) begin
      errors++; $display("FAIL clr_ovf ovf/pend got %0b/%0d want 0/%0d", ovf, pend_cnt, MAX_PEND);
    end
  endtask

  task automatic test_full_pop();
    logic [CNT_W-1:0] c0;
    logic             a0;
    c0 = evt_count;
    a0 = m_ack;
    flip();
    tick(SYNC_STAGES);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if (pend_cnt !== 4'(MAX_PEND) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_pop pend/ovf got %0d/%0b want %0d/0", pend_cnt, ovf, MAX_PEND);
    end
    checks++;
    if (evt_count !== c0 + CNT_W'(1)) begin
      errors++; $display("FAIL full_pop evt_count got %0d want %0d", evt_count, c0 + 1);
    end
    checks++;
    if (ack_tgl !== ~a0) begin
      errors++; $display("FAIL full_pop ack_tgl got %0b want %0b", ack_tgl, ~a0);
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b0);
    evt_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      flip();
      tick(4);
    end
    tick(4);
    evt_ready = 1'b0;
    checks++;
    if (evt_count !== CNT_W'(44)) begin
      errors++; $display("FAIL stream evt_count got %0d want 44", evt_count);
    end
    checks++;
    if (ack_tgl !== 1'b0 || ovf !== 1'b0 || pend_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stream ack/ovf/pend got %0b/%0b/%0d want 0/0/0", ack_tgl, ovf, pend_cnt);
    end
  endtask

  task automatic test_random();
    int gap;
    apply_reset(1'($urandom_range(0, 1)));
    gap = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      evt_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      if (gap == 0) begin
        flip();
        gap = SYNC_STAGES + 1 + $urandom_range(0, 3);
      end else begin
        gap--;
      end
      tick(1);
      checks++;
      if (pend_cnt !== 4'(m_pend) || evt_valid !== (m_pend != 0)) begin
        errors++;
        $display("FAIL rand cyc %0d pend/valid got %0d/%0b want %0d/%0b", cyc, pend_cnt,
                 evt_valid, m_pend, m_pend != 0);
      end
      checks++;
      if (evt_count !== CNT_W'(m_count) || ovf !== m_ovf || ack_tgl !== m_ack) begin
        errors++;
        $display("FAIL rand cyc %0d count/ovf/ack got %0d/%0b/%0b want %0d/%0b/%0b", cyc,
                 evt_count, ovf, ack_tgl, m_count, m_ovf, m_ack);
      end
    end
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    flip();
    tick(4);
    flip();
    tick(4);
    checks++;
    if (pend_cnt !== 4'd2 || tgl_in !== 1'b1) begin
      errors++; $display("FAIL async_reset setup pend_cnt got %0d want 2", pend_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || pend_cnt !== 4'd0 || evt_count !== '0 || ovf !== 1'b0 ||
        ack_tgl !== 1'b0) begin
      errors++;
      $display("FAIL async_reset outputs got v%0b p%0d c%0d o%0b a%0b want all 0", evt_valid,
               pend_cnt, evt_count, ovf, ack_tgl);
    end
    tick(2);
    rst_n = 1'b1;
    tick(12);
    checks++;
    if (evt_valid !== 1'b0 || pend_cnt !== 4'd0 || evt_count !== '0) begin
      errors++;
      $display("FAIL async_reset post v/p/c got %0b/%0d/%0d want 0/0/0", evt_valid, pend_cnt,
               evt_count);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tgl_in    = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_stream();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
